// File: rtl/aes_pkg.sv
// Shared AES column-engine types and GF(2^8) arithmetic helpers.
package aes_pkg;

    typedef enum logic [2:0] {
        OP_SUB    = 3'd0,
        OP_INVSUB = 3'd1,
        OP_MIX    = 3'd2,
        OP_INVMIX = 3'd3,
        OP_SUBMIX = 3'd4
    } aes_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SUB,
        ST_MIX,
        ST_DONE
    } aes_state_e;

    // Byte k holds the row-0 coefficient applied to a_k; other rows rotate it.
    localparam logic [31:0] MIX_FWD = 32'h0101_0302;
    localparam logic [31:0] MIX_INV = 32'h090d_0b0e;

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = gf_xtime(x);
        end
        return p;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [31:0] coef;
        logic [31:0] res;
        coef = inv ? MIX_INV : MIX_FWD;
        res  = 32'h0;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                res[8*r +: 8] = res[8*r +: 8] ^ gf_mul(coef[8*((k - r) & 3) +: 8], col[8*k +: 8]);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/aes_col_engine_if.sv
// Request/response handshake bundle between the execute stage and the AES column engine.
interface aes_col_engine_if #(
    parameter int W = 32
) ();
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_op;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_err;

    modport master (
        output in_valid, in_op, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_op, in_data, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/aes_sbox_bank.sv
// NSBOX parallel combinational AES S-box lanes; inv_i selects the inverse S-box.
module aes_sbox_bank
    import aes_pkg::*;
#(
    parameter int NSBOX = 4
) (
    input  logic               inv_i,
    input  logic [8*NSBOX-1:0] data_i,
    output logic [8*NSBOX-1:0] data_o
);

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = x15;
        for (int i = 0; i < 4; i++) x240 = gf_mul(x240, x240);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
        logic [7:0] v;
        v = gf_inv(b);
        return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] s);
        return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
    endfunction

    for (genvar i = 0; i < NSBOX; i++) begin : g_lane
        assign data_o[8*i +: 8] = inv_i ? sbox_inv(data_i[8*i +: 8]) : sbox_fwd(data_i[8*i +: 8]);
    end

endmodule

// File: rtl/aes_col_engine.sv
// Multi-cycle AES column engine (SubBytes/MixColumns and inverses) behind a valid/ready handshake.
// Optional fused AddRoundKey on the result when AES_KEYXOR_EN is defined.
module aes_col_engine
    import aes_pkg::*;
#(
    parameter int NCOL  = 1,
    parameter int NSBOX = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef AES_KEYXOR_EN
    input  logic [32*NCOL-1:0]   in_key,
`endif
    aes_col_engine_if.slave      bus
);

    localparam int W    = 32 * NCOL;
    localparam int SB_W = 8 * NSBOX;
    localparam int K    = (4 * NCOL) / NSBOX;
    localparam int BW   = (K > 1) ? $clog2(K) : 1;

    aes_state_e      state_q;
    logic [2:0]      op_q;
    logic [BW-1:0]   batch_q;
    logic [W-1:0]    work_q;
    logic [W-1:0]    out_data_q;
    logic            out_err_q;
    logic            out_valid_q;
    logic            in_ready_q;

    logic [SB_W-1:0] sbox_in, sbox_out;
    logic [W-1:0]    sub_d, mix_d;
    logic [W-1:0]    res_idle_d, res_sub_d, res_mix_d;
    logic            last_batch;

`ifdef AES_KEYXOR_EN
    logic [W-1:0]    key_q;
`endif

    aes_sbox_bank #(.NSBOX(NSBOX)) u_sbox (
        .inv_i  (op_q == OP_INVSUB),
        .data_i (sbox_in),
        .data_o (sbox_out)
    );

    always_comb begin
        sbox_in = work_q[int'(batch_q)*SB_W +: SB_W];
        sub_d   = work_q;
        sub_d[int'(batch_q)*SB_W +: SB_W] = sbox_out;
    end

    for (genvar c = 0; c < NCOL; c++) begin : g_mix
        assign mix_d[32*c +: 32] = mix_col(work_q[32*c +: 32], op_q == OP_INVMIX);
    end

    // Values written into out_data on entry to DONE, with the round key folded in when enabled.
    always_comb begin
        res_idle_d = bus.in_data;
        res_sub_d  = sub_d;
        res_mix_d  = mix_d;
`ifdef AES_KEYXOR_EN
        res_idle_d = bus.in_data ^ in_key;
        res_sub_d  = sub_d ^ key_q;
        res_mix_d  = mix_d ^ key_q;
`endif
    end

    assign last_batch = (batch_q == BW'(K - 1));

    // out_valid lags DONE entry by one cycle so it comes from a plain register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= 3'd0;
            batch_q     <= '0;
            work_q      <= '0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef AES_KEYXOR_EN
            key_q       <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        work_q     <= bus.in_data;
                        op_q       <= bus.in_op;
                        batch_q    <= '0;
                        in_ready_q <= 1'b0;
`ifdef AES_KEYXOR_EN
                        key_q      <= in_key;
`endif
                        case (bus.in_op)
                            OP_SUB, OP_INVSUB, OP_SUBMIX: state_q <= ST_SUB;
                            OP_MIX, OP_INVMIX:            state_q <= ST_MIX;
                            default: begin
                                state_q    <= ST_DONE;
                                out_data_q <= res_idle_d;
                                out_err_q  <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_SUB: begin
                    work_q  <= sub_d;
                    batch_q <= batch_q + 1'b1;
                    if (last_batch) begin
                        batch_q <= '0;
                        if (op_q == OP_SUBMIX) begin
                            state_q <= ST_MIX;
                        end else begin
                            state_q    <= ST_DONE;
                            out_data_q <= res_sub_d;
                            out_err_q  <= 1'b0;
                        end
                    end
                end
                ST_MIX: begin
                    work_q     <= mix_d;
                    state_q    <= ST_DONE;
                    out_data_q <= res_mix_d;
                    out_err_q  <= 1'b0;
                end
                ST_DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_aes_col_engine.sv
// Scoreboard bench for aes_col_engine: one default (NCOL=1,NSBOX=4) and one NCOL=4,NSBOX=1 instance.
module tb_aes_col_engine;
    import aes_pkg::*;

    typedef struct {
        logic [127:0] data;
        logic         err;
        int           lat;
    } exp_t;

`ifdef AES_KEYXOR_EN
    localparam bit KEY_ON = 1'b1;
`else
    localparam bit KEY_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  key1 = '0;
    logic [127:0] key4 = '0;
    int           edges = 0;
    int           n_chk = 0;
    int           n_fail = 0;

    exp_t sb0[$];
    exp_t sb1[$];
    int   t_acc [2];
    bit   busy  [2];
    bit   seen  [2];

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    aes_col_engine_if #(.W(32))  bus1 ();
    aes_col_engine_if #(.W(128)) bus4 ();

    aes_col_engine #(.NCOL(1), .NSBOX(4)) u_dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
`ifdef AES_KEYXOR_EN
        .in_key (key1),
`endif
        .bus    (bus1)
    );

    aes_col_engine #(.NCOL(4), .NSBOX(1)) u_dut4 (
        .clk    (clk),
        .rst_n  (rst_n),
`ifdef AES_KEYXOR_EN
        .in_key (key4),
`endif
        .bus    (bus4)
    );

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    function automatic int sb_size(input int d);
        return (d == 0) ? sb0.size() : sb1.size();
    endfunction

    task automatic mon(input int d, input logic iv, input logic ir, input logic ov,
                       input logic ordy, input logic [127:0] od, input logic oe);
        exp_t e;
        if (!rst_n) begin
            if (d == 0) sb0.delete(); else sb1.delete();
            busy[d] = 1'b0;
            seen[d] = 1'b0;
            return;
        end
        if (busy[d]) check_eq($sformatf("busy_in_ready%0d", d), 128'(ir), 128'(0));
        if (ov) begin
            if (sb_size(d) == 0) begin
                check_eq($sformatf("unexpected_out_valid%0d", d), 128'(ov), 128'(0));
            end else begin
                e = (d == 0) ? sb0[0] : sb1[0];
                if (!seen[d]) begin
                    check_eq($sformatf("latency%0d", d), 128'(edges - t_acc[d]), 128'(e.lat));
                    seen[d] = 1'b1;
                end
                check_eq($sformatf("out_data%0d", d), od, e.data);
                if (ordy) begin
                    check_eq($sformatf("out_err%0d", d), 128'(oe), 128'(e.err));
                    if (d == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
                    busy[d] = 1'b0;
                    seen[d] = 1'b0;
                end
            end
        end
        if (iv && ir) begin
            t_acc[d] = edges + 1;
            busy[d]  = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        mon(0, bus1.in_valid, bus1.in_ready, bus1.out_valid, bus1.out_ready,
            128'(bus1.out_data), bus1.out_err);
        mon(1, bus4.in_valid, bus4.in_ready, bus4.out_valid, bus4.out_ready,
            bus4.out_data, bus4.out_err);
    end

    task automatic drive(input int d, input logic [2:0] op, input logic [127:0] data,
                         input logic [127:0] key, input logic [127:0] raw,
                         input logic err, input int lat);
        exp_t e;
        int   n;
        e.data = raw ^ (KEY_ON ? key : 128'(0));
        e.err  = err;
        e.lat  = lat;
        n = 0;
        while (!((d == 0) ? bus1.in_ready : bus4.in_ready) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            check_eq("ready_timeout", 128'(n), 128'(0));
            return;
        end
        if (d == 0) begin
            sb0.push_back(e);
            bus1.in_valid = 1'b1; bus1.in_op = op; bus1.in_data = data[31:0]; key1 = key[31:0];
        end else begin
            sb1.push_back(e);
            bus4.in_valid = 1'b1; bus4.in_op = op; bus4.in_data = data; key4 = key;
        end
        @(posedge clk); #1;
        // Disturb the inputs after the accept edge; the engine must not see this.
        if (d == 0) begin
            bus1.in_valid = 1'b0; bus1.in_op = ~op; bus1.in_data = ~data[31:0]; key1 = ~key[31:0];
        end else begin
            bus4.in_valid = 1'b0; bus4.in_op = ~op; bus4.in_data = ~data; key4 = ~key;
        end
    endtask

    task automatic wait_done(input int d);
        int n;
        n = 0;
        while (sb_size(d) > 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_eq($sformatf("done_timeout%0d", d), 128'(sb_size(d)), 128'(0));
    endtask

    localparam logic [31:0]  K1 = 32'h0f0f_a5a5;
    localparam logic [127:0] K4 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    localparam logic [127:0] ALL63 = {16{8'h63}};

    initial begin
        int n;
        bus1.in_valid = 1'b0; bus1.in_op = 3'd0; bus1.in_data = '0; bus1.out_ready = 1'b1;
        bus4.in_valid = 1'b0; bus4.in_op = 3'd0; bus4.in_data = '0; bus4.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        check_eq("rst_in_ready1",  128'(bus1.in_ready),  128'(1));
        check_eq("rst_out_valid1", 128'(bus1.out_valid), 128'(0));
        check_eq("rst_out_data1",  128'(bus1.out_data),  128'(0));
        check_eq("rst_out_err1",   128'(bus1.out_err),   128'(0));
        check_eq("rst_in_ready4",  128'(bus4.in_ready),  128'(1));
        check_eq("rst_out_data4",  bus4.out_data,        128'(0));

        // NCOL=1, NSBOX=4
        drive(0, OP_SUB,    128'h5300_5300, K1, 128'hed63_ed63, 1'b0, 2);
        drive(0, OP_SUB,    128'h16ff_0100, K1, 128'h4716_7c63, 1'b0, 2);
        drive(0, OP_INVSUB, 128'h4716_7c63, K1, 128'h16ff_0100, 1'b0, 2);
        drive(0, OP_MIX,    128'h4553_13db, K1, 128'hbca1_4d8e, 1'b0, 2);
        drive(0, OP_INVMIX, 128'hbca1_4d8e, K1, 128'h4553_13db, 1'b0, 2);
        drive(0, OP_MIX,    128'h5c22_0af2, K1, 128'h9d58_dc9f, 1'b0, 2);
        drive(0, OP_INVMIX, 128'h9d58_dc9f, K1, 128'h5c22_0af2, 1'b0, 2);
        drive(0, OP_MIX,    128'h4c31_262d, K1, 128'hf8bd_7e4d, 1'b0, 2);
        drive(0, OP_SUBMIX, 128'h5300_5300, K1, 128'hea64_ea64, 1'b0, 3);
        drive(0, 3'd7,      128'h1234_5678, 128'hffff_ffff, 128'h1234_5678, 1'b1, 1);
        drive(0, 3'd5,      128'hcafe_f00d, K1, 128'hcafe_f00d, 1'b1, 1);
        wait_done(0);

        // Output held with out_ready low; in_valid pulses must not be accepted.
        bus1.out_ready = 1'b0;
        drive(0, OP_SUBMIX, 128'h0, K1, 128'h6363_6363, 1'b0, 3);
        n = 0;
        while (!bus1.out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("hold_wait_valid", 128'(bus1.out_valid), 128'(1));
        for (int i = 0; i < 5; i++) begin
            bus1.in_valid = (i % 2 == 0);
            bus1.in_op    = OP_MIX;
            bus1.in_data  = $urandom;
            @(posedge clk); #1;
            check_eq("hold_out_valid", 128'(bus1.out_valid), 128'(1));
        end
        bus1.in_valid  = 1'b0;
        bus1.out_ready = 1'b1;
        wait_done(0);

        // NCOL=4, NSBOX=1 (K=16)
        drive(1, OP_INVSUB, ALL63, K4, 128'h0, 1'b0, 17);
        drive(1, OP_SUB, 128'h0f0e_0d0c_0b0a_0908_0706_0504_0302_0100, K4,
              128'h76ab_d7fe_2b67_0130_c56f_6bf2_7b77_7c63, 1'b0, 17);
        drive(1, OP_MIX, 128'h0101_0101_4c31_262d_5c22_0af2_4553_13db, K4,
              128'h0101_0101_f8bd_7e4d_9d58_dc9f_bca1_4d8e, 1'b0, 2);
        drive(1, OP_INVMIX, 128'h0101_0101_f8bd_7e4d_9d58_dc9f_bca1_4d8e, K4,
              128'h0101_0101_4c31_262d_5c22_0af2_4553_13db, 1'b0, 2);
        drive(1, OP_SUBMIX, 128'h0, K4, ALL63, 1'b0, 18);
        wait_done(1);

        // Reset in the middle of SUB at batch 5; that operation must never complete.
        drive(1, OP_INVSUB, ALL63, K4, 128'h0, 1'b0, 17);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus4.in_valid = 1'b1;
        bus4.in_op    = 3'd7;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus4.in_valid = 1'b0;
        check_eq("midrst_in_ready",  128'(bus4.in_ready),  128'(1));
        check_eq("midrst_out_valid", 128'(bus4.out_valid), 128'(0));
        check_eq("midrst_out_data",  bus4.out_data,        128'(0));
        check_eq("midrst_out_err",   128'(bus4.out_err),   128'(0));
        repeat (30) @(posedge clk);
        #1;
        drive(1, OP_INVSUB, ALL63, K4, 128'h0, 1'b0, 17);
        drive(1, 3'd6, 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321, K4,
              128'h1234_5678_9abc_def0_0fed_cba9_8765_4321, 1'b1, 1);
        wait_done(1);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/aes_col_engine.md
# aes_col_engine

Multi-cycle, parametrised AES column engine for the RV32 AES custom-instruction datapath. It applies SubBytes, InvSubBytes, MixColumns, InvMixColumns or fused SubBytes→MixColumns to NCOL 32-bit state columns per operation. The S-box count is time-multiplexed over the bytes, and a valid/ready handshake connects the engine to the execute stage as a multi-cycle functional unit.

## Interface
- NCOL, 1: columns per operation, 1..4; data width W = 32*NCOL.
- NSBOX, 4: S-box lanes instantiated; must divide 4*NCOL.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  operation request.
- in_ready  out  1  engine can accept; high only in IDLE.
- in_op  in  3  opcode: 0 SUB, 1 INVSUB, 2 MIX, 3 INVMIX, 4 SUBMIX, 5–7 reserved.
- in_data  in  W  column j = bits [32j+31:32j]; row r = byte [8r+7:8r].
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  W  result.
- out_err  out  1  qualified by out_valid; 1 if the opcode was reserved.

## Operation
- States: IDLE, SUB, MIX, DONE.
- IDLE, when in_valid is high:
  - latch in_data, in_op and the key if enabled.
  - SUB, INVSUB, SUBMIX go to SUB with batch counter 0.
  - MIX, INVMIX go to MIX.
  - Reserved opcodes go to DONE with data unchanged and err = 1.
- SUB: each cycle, bytes [NSBOX*i .. NSBOX*i+NSBOX-1] of the working register pass through the S-boxes (inverse for INVSUB) and are written back.
  - After K = 4*NCOL/NSBOX cycles, SUBMIX goes to MIX; the others go to DONE.
- MIX: in one cycle, all NCOL columns get forward (SUB/MIX/SUBMIX) or inverse (INVMIX) MixColumns.
  - Forward: out0 = 2a0^3a1^a2^a3, rotated per row.
  - Inverse: coefficients {0e,0b,0d,09}.
  - All arithmetic is GF(2^8) mod 0x11b. Next state DONE.
- DONE: out_valid = 1 and out_data is held stable. On out_ready, go to IDLE.
- One operation is in flight at a time. Input is never accepted in the same cycle as out_ready.
- Any cycle with rst_n = 0:
  - next state IDLE, the working register is cleared, and an in-flight operation is discarded with no output.
  - in_valid is ignored in that cycle.

## Timing
- Reset values: out_valid 0, out_data 0, out_err 0; in_ready 1 from the cycle after reset.
- Accept at edge T. out_valid rises after edge:
  - T+1 for reserved opcodes
  - T+K+1 for SUB and INVSUB
  - T+2 for MIX and INVMIX
  - T+K+2 for SUBMIX
- Latency with defaults (NCOL = 1, NSBOX = 4, K = 1): 2 cycles for SUB, 2 for MIX, 3 for SUBMIX.
- out_valid stays high until the out_ready edge. The engine returns to IDLE on the following cycle, so the next accept is one cycle after the output handshake.
- in_data and in_op are sampled only at the accept edge. Later input changes have no effect.

## Configuration
- AES_KEYXOR_EN defined:
  - adds port in_key (in, W), latched at accept.
  - DONE data = result ^ key for every opcode, including reserved (fused AddRoundKey).
  - latency is unchanged: the XOR is applied on entry to DONE.
- Not defined: no in_key port and no XOR logic.

## Structure
- Package aes_pkg holds:
  - the opcode enum and the state enum.
  - the gf_xtime and gf_mul functions.
  - the forward and inverse MixColumns coefficient constants.
- Sub-module aes_sbox_bank: NSBOX parallel forward/inverse S-box lanes, purely combinational, with an inv select.
- The engine top holds the FSM, batch counter, working register, MixColumns logic and key XOR.

## Test plan
- SUB, NCOL=1, NSBOX=4, in_data=32'h5300_5300 → out_data=32'hed63_ed63 after 2 cycles, out_err=0.
- MIX, in_data=32'h4553_13db → 32'hbca1_4d8e. INVMIX of 32'hbca1_4d8e → 32'h4553_13db.
- NCOL=4, NSBOX=1, INVSUB, all bytes 0x63 → all bytes 0x00. out_valid exactly 17 cycles after accept; in_ready=0 throughout.
- SUBMIX, then hold out_ready=0 for 5 cycles → out_data stable with out_valid=1. in_valid pulses during that window are not accepted.
- Reserved op 7, in_data=32'h1234_5678 → output unchanged, out_err=1, after 1 cycle. With AES_KEYXOR_EN and key=32'hffff_ffff → 32'hedcb_a987.
- Assert rst_n=0 mid-SUB (NCOL=4, NSBOX=1, batch 5) → out_valid never rises for that op; next op after reset completes correctly.
